// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-state constants and control-word bit positions.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef logic [5:0] t_state_t;

    localparam t_state_t T1 = 6'b000001;
    localparam t_state_t T2 = 6'b000010;
    localparam t_state_t T3 = 6'b000100;
    localparam t_state_t T4 = 6'b001000;
    localparam t_state_t T5 = 6'b010000;
    localparam t_state_t T6 = 6'b100000;

    localparam int unsigned T4_IDX = 3;

    // Bit positions within the 14-bit cw_bus; _N entries are active-low strobes.
    localparam int unsigned CW_W    = 14;
    localparam int unsigned CW_CP   = 13;
    localparam int unsigned CW_EP   = 12;
    localparam int unsigned CW_LM_N = 11;
    localparam int unsigned CW_CE_N = 10;
    localparam int unsigned CW_LI_N = 9;
    localparam int unsigned CW_EI_N = 8;
    localparam int unsigned CW_LA_N = 7;
    localparam int unsigned CW_EA   = 6;
    localparam int unsigned CW_SU   = 5;
    localparam int unsigned CW_EU   = 4;
    localparam int unsigned CW_LB_N = 3;
    localparam int unsigned CW_LO_N = 2;
    localparam int unsigned CW_HLT  = 1;
    localparam int unsigned CW_RSVD = 0;

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot left-rotating T-state counter, clocked on the falling edge, with freeze and wrap pulse.
module sap1_ring_counter #(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         freeze_i,
    output logic [N-1:0] t_state_o,
    output logic         wrap_o
);

    localparam logic [N-1:0] One = N'(1);

    logic [N-1:0] state_q;
    logic [N-1:0] state_d;
    logic         onehot_ok;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= One;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        onehot_ok = (state_q != '0) && ((state_q & (state_q - One)) == '0);
        if (!onehot_ok) begin
            // Recover to T1 if the one-hot invariant is ever lost.
            state_d = One;
        end else if (!freeze_i) begin
            state_d = {state_q[N-2:0], state_q[N-1]};
        end
    end

    always_comb begin
        t_state_o = state_q;
        wrap_o    = state_q[N-1] & ~freeze_i;
    end

endmodule

// File: rtl/sap1_ir_sequencer.sv
// SAP-1 instruction register, T-state sequencing, halt latch and saturating retired count.
module sap1_ir_sequencer
    import sap1_pkg::*;
#(
    parameter int unsigned WORD_W            = 8,
    parameter int unsigned OP_W              = 4,
    parameter int unsigned T_STATES          = 6,
    parameter logic [OP_W-1:0] HLT_OPCODE    = OP_HLT,
    parameter int unsigned CNT_W             = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_W-1:0]      w_bus_in_i,
    input  logic                   li_n_i,
    input  logic                   ei_n_i,
    output logic [OP_W-1:0]        opcode_o,
    output logic [WORD_W-OP_W-1:0] addr_out_o,
    output logic                   addr_oe_o,
    output logic [T_STATES-1:0]    t_state_o,
    output logic                   halted_o,
    output logic [CNT_W-1:0]       retired_cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [WORD_W-1:0]   ir_q, ir_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [T_STATES-1:0] t_state;
    logic                wrap;
    logic                halt_now;
    logic                freeze;

    assign halt_now = ~halted_q & t_state[T4_IDX] & (ir_q[WORD_W-1 -: OP_W] == HLT_OPCODE);
    // Freezing on the detection edge itself keeps the counter parked at T4.
    assign freeze   = halted_q | halt_now;

    sap1_ring_counter #(
        .N(T_STATES)
    ) u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .freeze_i (freeze),
        .t_state_o(t_state),
        .wrap_o   (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    // Halt latch and retired count share the ring counter's falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (!li_n_i && !halted_q) begin
            ir_d = w_bus_in_i;
        end
    end

    always_comb begin
        halted_d = halted_q | halt_now;
        cnt_d    = cnt_q;
        if (wrap && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        opcode_o      = ir_q[WORD_W-1 -: OP_W];
        addr_oe_o     = ~ei_n_i;
        addr_out_o    = ei_n_i ? '0 : ir_q[WORD_W-OP_W-1:0];
        t_state_o     = t_state;
        halted_o      = halted_q;
        retired_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_sap1_ir_sequencer.sv
// Randomised bench for sap1_ir_sequencer against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_sap1_ir_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] w;
    logic       li_n;
    logic       ei_n;
    logic [3:0] opcode;
    logic [3:0] addr_out;
    logic       addr_oe;
    logic [5:0] t_state;
    logic       halted;
    logic [7:0] retired;

    int total = 0;
    int bad   = 0;

    // Reference model: T-state index, halt flag, IR byte, retired count.
    int         m_t;
    bit         m_halt;
    logic [7:0] m_ir;
    int         m_cnt;

    sap1_ir_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_bus_in_i   (w),
        .li_n_i       (li_n),
        .ei_n_i       (ei_n),
        .opcode_o     (opcode),
        .addr_out_o   (addr_out),
        .addr_oe_o    (addr_oe),
        .t_state_o    (t_state),
        .halted_o     (halted),
        .retired_cnt_o(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_t    = 0;
        m_halt = 0;
        m_ir   = 8'h00;
        m_cnt  = 0;
    endtask

    // One full clock: IR on the rising edge, ring/halt/count on the falling edge; ends 1ns later.
    task automatic cycle();
        @(posedge clk);
        if (!li_n && !m_halt) m_ir = w;
        @(negedge clk);
        if (!m_halt) begin
            if (m_t == 3 && m_ir[7:4] == 4'hF) begin
                m_halt = 1;
            end else if (m_t == 5) begin
                m_t = 0;
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_t++;
            end
        end
        #1;
    endtask

    // Called in the low phase just after a falling edge.
    task automatic do_reset();
        li_n = 1'b1;
        ei_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [5:0] exp_t();
        logic [5:0] one;
        one = 6'b000001;
        return one << m_t;
    endfunction

    task automatic test_reset();
        cycle();
        cycle();
        total++;
        if (t_state !== 6'b000100) begin
            bad++;
            $display("FAIL reset_pre_t3 t_state got=%b exp=%b", t_state, 6'b000100);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (t_state !== 6'b000001) begin
            bad++;
            $display("FAIL reset_t_state got=%b exp=%b", t_state, 6'b000001);
        end
        total++;
        if (halted !== 1'b0 || opcode !== 4'h0 || retired !== 8'h00 || addr_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got halted=%b op=%h cnt=%h oe=%b exp 0/0/00/0",
                     halted, opcode, retired, addr_oe);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_ring();
        logic [5:0] ts;
        for (int i = 0; i < 12; i++) begin
            cycle();
            ts = t_state;
            total++;
            if (ts !== exp_t() || $countones(ts) != 1) begin
                bad++;
                $display("FAIL ring_step%0d t_state got=%b exp=%b", i, ts, exp_t());
            end
        end
        total++;
        if (retired !== 8'd2) begin
            bad++;
            $display("FAIL ring_retired got=%0d exp=2", retired);
        end
    endtask

    task automatic test_load();
        do_reset();
        w    = 8'h2B;
        li_n = 1'b0;
        cycle();
        li_n = 1'b1;
        total++;
        if (opcode !== 4'h2 || addr_out !== 4'h0 || addr_oe !== 1'b0) begin
            bad++;
            $display("FAIL load_hidden got op=%h addr=%h oe=%b exp op=2 addr=0 oe=0",
                     opcode, addr_out, addr_oe);
        end
        ei_n = 1'b0;
        #1;
        total++;
        if (addr_out !== 4'hB || addr_oe !== 1'b1) begin
            bad++;
            $display("FAIL load_enabled got addr=%h oe=%b exp addr=b oe=1", addr_out, addr_oe);
        end
        ei_n = 1'b1;
    endtask

    task automatic test_halt();
        logic [7:0] cnt_before;
        bit         stuck;
        do_reset();
        cycle();
        cycle();
        w    = 8'hF0;
        li_n = 1'b0;
        cycle();
        li_n = 1'b1;
        cnt_before = retired;
        total++;
        if (t_state !== 6'b001000 || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_pre got t=%b h=%b exp t=001000 h=0", t_state, halted);
        end
        cycle();
        total++;
        if (halted !== 1'b1 || halted !== m_halt) begin
            bad++;
            $display("FAIL halt_set got=%b exp=1", halted);
        end
        stuck = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (t_state !== 6'b001000) stuck = 0;
        end
        total++;
        if (!stuck) begin
            bad++;
            $display("FAIL halt_frozen t_state got=%b exp=001000", t_state);
        end
        w    = 8'h11;
        li_n = 1'b0;
        cycle();
        li_n = 1'b1;
        total++;
        if (opcode !== 4'hF) begin
            bad++;
            $display("FAIL halt_no_load opcode got=%h exp=f", opcode);
        end
        total++;
        if (retired !== cnt_before || halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_cnt got=%0d h=%b exp=%0d h=1", retired, halted, cnt_before);
        end
    endtask

    task automatic test_collision();
        do_reset();
        w    = 8'h15;
        li_n = 1'b0;
        cycle();
        w    = 8'h3C;
        ei_n = 1'b0;
        #1;
        total++;
        if (addr_out !== 4'h5) begin
            bad++;
            $display("FAIL collision_before addr got=%h exp=5", addr_out);
        end
        cycle();
        total++;
        if (addr_out !== 4'hC || opcode !== 4'h3) begin
            bad++;
            $display("FAIL collision_after got addr=%h op=%h exp addr=c op=3", addr_out, opcode);
        end
        li_n = 1'b1;
        ei_n = 1'b1;
    endtask

    // Compares every observable against the model; random loads, optionally including HLT.
    task automatic run_random(input int n, input bit allow_hlt, input string tag);
        int         errs;
        logic [7:0] exp_addr;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            w    = {allow_hlt ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 14)),
                    4'($urandom_range(0, 15))};
            li_n = ($urandom_range(0, 3) != 0);
            ei_n = $urandom_range(0, 1) != 0;
            cycle();
            exp_addr = ei_n ? 8'h00 : {4'h0, m_ir[3:0]};
            total++;
            if (t_state !== exp_t() || opcode !== m_ir[7:4] || addr_out !== exp_addr[3:0] ||
                addr_oe !== ~ei_n || halted !== m_halt || retired !== 8'(m_cnt)) begin
                bad++;
                errs++;
                if (errs < 5)
                    $display("FAIL %s cyc%0d got t=%b op=%h a=%h h=%b c=%0d exp t=%b op=%h a=%h h=%b c=%0d",
                             tag, i, t_state, opcode, addr_out, halted, retired,
                             exp_t(), m_ir[7:4], exp_addr[3:0], m_halt, m_cnt);
            end
        end
        li_n = 1'b1;
        ei_n = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        run_random(260 * 6, 1'b0, "sat_random");
        total++;
        if (retired !== 8'hFF) begin
            bad++;
            $display("FAIL sat_final got=%h exp=ff", retired);
        end
        for (int i = 0; i < 6; i++) cycle();
        total++;
        if (retired !== 8'hFF) begin
            bad++;
            $display("FAIL sat_hold got=%h exp=ff", retired);
        end
    endtask

    task automatic test_random_halt();
        for (int k = 0; k < 4; k++) begin
            do_reset();
            run_random(60, 1'b1, "rand_halt");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        w     = 8'h00;
        li_n  = 1'b1;
        ei_n  = 1'b1;
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_ring();
        test_load();
        test_halt();
        test_collision();
        test_saturation();
        test_random_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
